// File: rtl/drm_arb_ctrl_if.sv
// Client-side bus of drm_arb_ctrl: two request channels, their read responses
// and the clear-done flag. master = client engines, slave = arbiter.
interface drm_arb_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;

    logic                  rsp0_valid;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_rdata, init_done
    );
endinterface

// File: rtl/drm_arb_ctrl.sv
// Round-robin two-requester arbiter for a simple dual-port block RAM with
// 1-cycle read latency; clears the RAM after reset before accepting requests.
module drm_arb_ctrl #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter bit                    INIT_CLEAR = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    drm_arb_ctrl_if.slave         bus,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_rst
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam state_e                RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  last_grant_q;   // 1 = requester 1 won the most recent grant
    logic                  rsp0_q, rsp1_q;
    logic                  grant0, grant1;

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_addr = rd_addr_q;

        // Gating on rst_n keeps the RAM write port quiet while reset is held.
        if (rst_n) begin
            unique case (state_q)
                ST_INIT: begin
                    ram_wr_en   = 1'b1;
                    ram_wr_addr = clr_cnt_q;
                    ram_wr_data = INIT_VALUE;
                    clr_cnt_d   = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
                    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
                    if (grant0) begin
                        if (bus.req0_we) begin
                            ram_wr_en   = 1'b1;
                            ram_wr_addr = bus.req0_addr;
                            ram_wr_data = bus.req0_wdata;
                        end else begin
                            ram_rd_addr = bus.req0_addr;
                        end
                    end
                    if (grant1) begin
                        if (bus.req1_we) begin
                            ram_wr_en   = 1'b1;
                            ram_wr_addr = bus.req1_addr;
                            ram_wr_data = bus.req1_wdata;
                        end else begin
                            ram_rd_addr = bus.req1_addr;
                        end
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            rd_addr_q    <= '0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rd_addr_q <= ram_rd_addr;
            if (grant0 || grant1) begin
                last_grant_q <= grant1;
            end
            rsp0_q <= grant0 && !bus.req0_we;
            rsp1_q <= grant1 && !bus.req1_we;
        end
    end

    // RAM output is unregistered, so read data arrives with the response pulse.
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_rdata  = ram_rd_data;
    assign bus.init_done  = (state_q == ST_RUN);
    assign ram_rst        = ~rst_n;

endmodule

// File: tb/tb_drm_arb_ctrl.sv
// Randomized scoreboard bench for drm_arb_ctrl: a behavioural RAM plus a
// round-robin/shadow-memory reference model predict grants and read responses.
module tb_drm_arb_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;

    drm_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    drm_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_nc ();

    logic          ram_wr_en, ram_rst;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_q;

    logic          nc_wr_en, nc_rst;
    logic [AW-1:0] nc_wr_addr, nc_rd_addr;
    logic [DW-1:0] nc_wr_data;

    drm_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_CLEAR(1'b1), .INIT_VALUE('0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_q), .ram_rst(ram_rst)
    );

    drm_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_CLEAR(1'b0), .INIT_VALUE('0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .bus(bus_nc),
        .ram_wr_en(nc_wr_en), .ram_wr_addr(nc_wr_addr), .ram_wr_data(nc_wr_data),
        .ram_rd_addr(nc_rd_addr), .ram_rd_data('0), .ram_rst(nc_rst)
    );

    // Behavioural 1-cycle-latency block RAM.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
        ram_q <= ram_mem[ram_rd_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Request drivers.
    logic          r_v   [2];
    logic          r_we  [2];
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wd  [2];

    assign bus.req0_valid = r_v[0];
    assign bus.req0_we    = r_we[0];
    assign bus.req0_addr  = r_addr[0];
    assign bus.req0_wdata = r_wd[0];
    assign bus.req1_valid = r_v[1];
    assign bus.req1_we    = r_we[1];
    assign bus.req1_addr  = r_addr[1];
    assign bus.req1_wdata = r_wd[1];

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        r_v[p]    = v;
        r_we[p]   = we;
        r_addr[p] = addr;
        r_wd[p]   = wd;
    endtask

    // Reference model: shadow memory contents plus the identity of the last winner.
    logic [DW-1:0] shadow [DEPTH];
    int            model_last = 1;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        longint        due;
    } exp_t;
    exp_t sb[$];

    task automatic eval(output int winner);
        @(negedge clk);
        if (r_v[0] && r_v[1])  winner = (model_last == 0) ? 1 : 0;
        else if (r_v[0])       winner = 0;
        else if (r_v[1])       winner = 1;
        else                   winner = -1;
        check("ready0", bus.req0_ready, winner == 0);
        check("ready1", bus.req1_ready, winner == 1);
        if (winner >= 0) begin
            if (r_we[winner]) shadow[r_addr[winner]] = r_wd[winner];
            else sb.push_back('{winner, shadow[r_addr[winner]], cyc + 1});
            model_last = winner;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("rsp_port", {bus.rsp1_valid, bus.rsp0_valid}, (e.port == 0) ? 2'b01 : 2'b10);
                check("rsp_data", bus.rsp_rdata, e.data);
                check("rsp_cycle", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("rsp_missing", {bus.rsp1_valid, bus.rsp0_valid}, (e.port == 0) ? 2'b01 : 2'b10);
        end
    end

    // Observe the clear from reset release; stop_at < 0 runs it to completion.
    task automatic do_clear(input int stop_at);
        int bad_en = 0, bad_addr = 0, bad_data = 0, bad_rdy = 0, bad_done = 0;
        int n = (stop_at < 0) ? DEPTH : stop_at + 1;
        logic [AW-1:0] ia;
        set_req(0, 1'b1, 1'b0, 12'h001, '0);
        set_req(1, 1'b1, 1'b1, 12'h002, 32'h5555_aaaa);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ia = i[AW-1:0];
            if (ram_wr_en !== 1'b1)                  bad_en++;
            if (ram_wr_addr !== ia)                  bad_addr++;
            if (ram_wr_data !== '0)                  bad_data++;
            if (bus.req0_ready || bus.req1_ready)    bad_rdy++;
            if (bus.init_done !== 1'b0)              bad_done++;
        end
        check("clr_wr_en_cycles", bad_en, 0);
        check("clr_addr_seq", bad_addr, 0);
        check("clr_data", bad_data, 0);
        check("clr_no_ready", bad_rdy, 0);
        check("clr_done_low", bad_done, 0);
        if (stop_at < 0) begin
            advance();
            r_v[0] = 1'b0;
            r_v[1] = 1'b0;
            @(negedge clk);
            check("init_done_rise", bus.init_done, 1'b1);
            check("wr_en_after_clear", ram_wr_en, 1'b0);
            for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
            advance();
        end
    endtask

    task automatic assert_reset();
        rst_n      = 1'b0;
        r_v[0]     = 1'b0;
        r_v[1]     = 1'b0;
        model_last = 1;
        sb.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        assert_reset();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        bus_nc.req0_valid = 1'b1;
        bus_nc.req0_we    = 1'b1;
        bus_nc.req0_addr  = 12'h005;
        bus_nc.req0_wdata = 32'h1234_5678;
        bus_nc.req1_valid = 1'b0;
        bus_nc.req1_we    = 1'b0;
        bus_nc.req1_addr  = '0;
        bus_nc.req1_wdata = '0;

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", bus.req0_ready, 1'b0);
        check("rst_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        check("rst_init_done", bus.init_done, 1'b0);
        check("rst_wr_en", ram_wr_en, 1'b0);
        check("rst_wr_addr", ram_wr_addr, 12'h000);
        check("rst_rd_addr", ram_rd_addr, 12'h000);
        check("rst_ram_rst", ram_rst, 1'b1);
        check("nc_rst_init_done", bus_nc.init_done, 1'b1);
        check("nc_rst_ready0", bus_nc.req0_ready, 1'b0);

        @(posedge clk);
        #3 rst_n = 1'b1;
        fork
            do_clear(-1);
            begin
                @(negedge clk);
                check("nc_first_ready0", bus_nc.req0_ready, 1'b1);
                check("nc_first_init_done", bus_nc.init_done, 1'b1);
                check("nc_first_wr_en", nc_wr_en, 1'b1);
                check("nc_first_wr_addr", nc_wr_addr, 12'h005);
                advance();
                bus_nc.req0_valid = 1'b0;
            end
        join

        // Continuous contention: grants alternate starting with requester 0.
        set_req(0, 1'b1, 1'b0, 12'h010, '0);
        set_req(1, 1'b1, 1'b0, 12'h020, '0);
        repeat (6) begin eval(w); advance(); end
        r_v[0] = 1'b0;
        r_v[1] = 1'b0;
        repeat (2) begin eval(w); advance(); end

        // Write then read-after-write on requester 0.
        set_req(0, 1'b1, 1'b1, 12'h123, 32'hDEAD_BEEF);
        eval(w); advance();
        set_req(0, 1'b1, 1'b0, 12'h123, '0);
        eval(w); advance();
        r_v[0] = 1'b0;
        @(negedge clk);
        check("raw_rsp0", bus.rsp0_valid, 1'b1);
        check("raw_rsp1", bus.rsp1_valid, 1'b0);
        check("raw_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        advance();

        // Requester 1 alone, then a tie that requester 0 must win.
        for (int k = 0; k < 5; k++) begin
            set_req(1, 1'b1, k[0], 12'h040 + 12'(k), $urandom);
            eval(w); advance();
        end
        set_req(0, 1'b1, 1'b0, 12'h123, '0);
        set_req(1, 1'b1, 1'b0, 12'h041, '0);
        repeat (3) begin eval(w); advance(); end

        // Randomized traffic with hold-while-pending.
        for (int n = 0; n < 400; n++) begin
            eval(w); advance();
            for (int p = 0; p < 2; p++) begin
                if (p == w || !r_v[p])
                    set_req(p, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                            12'($urandom_range(0, 31)), $urandom);
            end
        end
        r_v[0] = 1'b0;
        r_v[1] = 1'b0;
        repeat (3) begin eval(w); advance(); end

        // Reset with a read in flight: the response must never appear.
        set_req(0, 1'b1, 1'b0, 12'h123, '0);
        eval(w);
        assert_reset();
        repeat (2) begin
            @(negedge clk);
            check("abort_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Reset mid-clear at 0x800, then a full restart from address 0.
        do_clear(12'h800);
        assert_reset();
        @(negedge clk);
        check("midclear_wr_en", ram_wr_en, 1'b0);
        check("midclear_init_done", bus.init_done, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        do_clear(-1);

        // Memory is cleared again after the restart.
        set_req(0, 1'b1, 1'b0, 12'h123, '0);
        set_req(1, 1'b1, 1'b0, 12'h010, '0);
        eval(w); advance();
        eval(w); advance();
        r_v[0] = 1'b0;
        r_v[1] = 1'b0;
        repeat (3) begin eval(w); advance(); end

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drm_arb_ctrl.md
Name: drm_arb_ctrl

Overview:
- Two-requester arbiter and init sequencer for one single-clock simple dual-port block RAM (32x4096 instance: 1-cycle read latency, no output register).
- Clears the RAM after reset, then grants one requester access (read or write) per cycle with round-robin fairness.
- Returns read data to the requester that issued the read.
- Sits between the RAM instance (write/read ports tied to one clock) and two client engines.

Parameters:
- ADDR_WIDTH, 12, RAM address width (depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 32, RAM data width.
- INIT_CLEAR, 1, 1 = write INIT_VALUE to every address after reset; 0 = go straight to RUN.
- INIT_VALUE, 0, DATA_WIDTH-wide fill word used by the clear sequence.

Ports:
- clk, input, 1, single clock for controller and both RAM ports.
- rst_n, input, 1, asynchronous active-low reset.
- req0_valid / req1_valid, input, 1 each, request pending.
- req0_we / req1_we, input, 1 each, 1 = write, 0 = read.
- req0_addr / req1_addr, input, ADDR_WIDTH each, access address.
- req0_wdata / req1_wdata, input, DATA_WIDTH each, write data.
- req0_ready / req1_ready, output, 1 each, request accepted this cycle.
- rsp0_valid / rsp1_valid, output, 1 each, read data valid.
- rsp_rdata, output, DATA_WIDTH, read data, shared by both requesters; qualified by rspN_valid.
- init_done, output, 1, clear sequence finished.
- ram_wr_en, output, 1, to RAM wr_en.
- ram_wr_addr, output, ADDR_WIDTH, to RAM wr_addr.
- ram_wr_data, output, DATA_WIDTH, to RAM wr_data.
- ram_rd_addr, output, ADDR_WIDTH, to RAM rd_addr.
- ram_rd_data, input, DATA_WIDTH, from RAM rd_data.
- ram_rst, output, 1, to RAM wr_rst/rd_rst; equals ~rst_n.

Behaviour:
- Reset values: reqN_ready=0, rspN_valid=0, init_done=0, ram_wr_en=0, ram_wr_addr=0, ram_rd_addr=0, clear counter=0, last_grant=1 (so requester 0 wins the first tie), state=INIT (RUN if INIT_CLEAR=0, init_done=1).
- FSM INIT:
  - Each cycle: ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=INIT_VALUE; counter increments.
  - reqN_ready=0 throughout.
  - After writing address 2**ADDR_WIDTH-1: go to RUN; init_done=1 from the next cycle.
  - The clear takes exactly 2**ADDR_WIDTH cycles (4096 by default).
- FSM RUN, arbitration (combinational per cycle):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates on every grant.
  - reqN_ready = grantN. A transfer occurs when valid && ready.
  - Requesters hold addr/we/wdata stable while valid && !ready.
- Granted write:
  - ram_wr_en=1, ram_wr_addr=addr, ram_wr_data=wdata, all combinational in the grant cycle.
  - The RAM captures on that clk edge; no response is generated.
- Granted read:
  - ram_rd_addr=addr in the grant cycle T.
  - rspN_valid=1 in cycle T+1, with rsp_rdata = ram_rd_data (pass-through).
  - The response is a single-cycle pulse with no backpressure; the requester must sink it.
- ram_rd_addr holds its last value when no read is granted.
- ram_wr_en=0 in RUN when no write is granted.
- Read-after-write:
  - A write accepted in cycle T followed by a read of the same address in T+1 returns the new data.
  - A same-cycle collision cannot occur (one grant per cycle).
- Back-to-back: one accepted request per cycle is sustainable; alternating grants under continuous contention.
- Reset mid-operation:
  - Asserting rst_n low drops all outputs to reset values immediately and aborts any pending response (no rspN_valid).
  - On release the clear restarts at address 0.

Test Plan:
- Release reset, INIT_CLEAR=1 -> exactly 4096 ram_wr_en cycles, addresses 0..4095 with data 0; init_done rises the cycle after address 4095; no reqN_ready during INIT.
- After init, req0 writes 0xDEADBEEF at 0x123, then reads 0x123 next cycle -> rsp0_valid pulses one cycle after the read grant with rsp_rdata=0xDEADBEEF; rsp1_valid stays 0.
- Both requesters continuously valid (reads at 0x010 and 0x020) -> grants alternate 0,1,0,1 starting with 0; responses route to matching rspN_valid with the correct data.
- req1 alone valid for 5 cycles -> granted every cycle; then both valid -> requester 0 wins the first tie.
- rst_n asserted while a read is in flight and mid-clear at address 0x800 -> rspN_valid never asserts; after release the clear restarts from 0 and takes 4096 cycles.
- INIT_CLEAR=0 -> init_done=1 and req0 accepted in the first cycle after reset release.
